pong_referee: RTL and testbench
===============================

PONG_REFEREE -- requirements
Module: pong_referee

Interface
REQ-001 Parameter PADDLE_TICK, default 250000, clock cycles between paddle steps.
REQ-002 Parameter WIN_SCORE, default 7, points that end a game (legal range 1..15).
REQ-003 clk  input  1  single system clock, all state on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 xPosition  input  6  ball column from the ball mover, 0..63.
REQ-006 yPosition  input  5  ball row from the ball mover, 0..31.
REQ-007 leftUp, leftDown, rightUp, rightDown  input  1 each  paddle buttons, active-high, already synchronised.
REQ-008 serve  input  1  serve/restart button, active-high, already synchronised.
REQ-009 isHittingLeft, isHittingRight  output  1 each  paddle-contact flags to the ball mover.
REQ-010 leftPaddleY, rightPaddleY  output  5 each  paddle top row.
REQ-011 leftScore, rightScore  output  4 each  points per player.
REQ-012 ballReset  output  1  active-low hold/restart of the ball mover (0 = ball held at start position).
REQ-013 gameOver  output  1  high while a winner is displayed.

Function
REQ-014 Paddle spans rows paddleY..paddleY+3; paddleY SHALL be clamped to 1..27.
REQ-015 A free-running tick counter SHALL pulse once every PADDLE_TICK cycles; paddles move only on tick cycles.
REQ-016 On tick: Up alone -> paddleY-1, Down alone -> paddleY+1, both or neither -> hold; a move past a limit SHALL saturate (no wrap).
REQ-017 isHittingLeft SHALL be registered, 1 cycle latency: high in the cycle after xPosition==1 and leftPaddleY <= yPosition <= leftPaddleY+3.
REQ-018 isHittingRight, same rule with xPosition==62 and rightPaddleY.
REQ-019 Hit flags SHALL be 0 outside state PLAY.
REQ-020 FSM states: SERVE, PLAY, POINT, GAME_OVER.
REQ-021 SERVE: ballReset=0; rising edge of serve (registered-edge detect) -> PLAY.
REQ-022 PLAY: ballReset=1; xPosition==0 -> POINT with rightScore credited; xPosition==63 -> POINT with leftScore credited.
REQ-023 POINT lasts exactly one cycle: the credited score SHALL increment by 1, saturating at 15; if the new score equals WIN_SCORE -> GAME_OVER, else -> SERVE.
REQ-024 GAME_OVER: ballReset=0, gameOver=1, scores frozen; a rising edge of serve SHALL clear both scores to 0 and go to SERVE.
REQ-025 A serve held high across states SHALL NOT re-trigger; only a new 0->1 edge counts.
REQ-026 Paddles SHALL keep moving in every state.
REQ-027 The miss check SHALL be evaluated only in PLAY; x==0 and x==63 cannot coincide, so no tie rule is needed.

Reset
REQ-028 While reset==0: state=SERVE, ballReset=0, gameOver=0, both scores 0, both paddleY=14, hit flags 0, tick counter 0, serve-edge register 0.
REQ-029 Reset asserted mid-game SHALL abort immediately with no score update.

Structure
REQ-030 Shared package pong_pkg SHALL hold the field constants (X_LEFT_HIT=1, X_RIGHT_HIT=62, X_LEFT_MISS=0, X_RIGHT_MISS=63, Y_TOP=1, Y_BOTTOM=30, PADDLE_H=4, PADDLE_Y_MAX=27, PADDLE_Y_RESET=14) and the FSM state enum.
REQ-031 Sub-module paddle_ctrl (up, down, tick -> clamped paddleY) SHALL be instantiated twice; tick generator, hit logic, scoring and FSM are in pong_referee.

Verification (PADDLE_TICK=4 on the bench)
REQ-032 Reset, then leftUp held for 20 ticks -> leftPaddleY steps 14,13,...,1 and stays 1; rightUp+rightDown together -> rightPaddleY stays 14.
REQ-033 PLAY with leftPaddleY=10, drive x=1, y=13 -> isHittingLeft=1 next cycle; y=14 -> 0; y=9 -> 0.
REQ-034 SERVE, pulse serve -> ballReset 0->1; drive x=0 -> one-cycle POINT, rightScore 0->1, ballReset=0, state SERVE.
REQ-035 Left at 6 points, drive x=63 -> leftScore=7, gameOver=1; serve held from before -> no change; new serve edge -> scores 0, gameOver=0, SERVE.
REQ-036 Assert reset while in PLAY with x=0 -> scores stay 0, paddles 14, ballReset=0, no POINT cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared field geometry, FSM state type and small helpers for the pong referee.
package pong_pkg;

  // Columns that mean "ball at a paddle face" and "ball past a paddle"
  localparam logic [5:0] X_LEFT_HIT   = 6'd1;
  localparam logic [5:0] X_RIGHT_HIT  = 6'd62;
  localparam logic [5:0] X_LEFT_MISS  = 6'd0;
  localparam logic [5:0] X_RIGHT_MISS = 6'd63;

  // Playfield rows and paddle geometry
  localparam logic [4:0] Y_TOP          = 5'd1;
  localparam logic [4:0] Y_BOTTOM       = 5'd30;
  localparam logic [4:0] PADDLE_H       = 5'd4;
  localparam logic [4:0] PADDLE_Y_MAX   = 5'd27;
  localparam logic [4:0] PADDLE_Y_RESET = 5'd14;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  // True when row y lies on a paddle whose top row is top (top..top+PADDLE_H-1)
  function automatic logic in_paddle(input logic [4:0] y, input logic [4:0] top);
    logic [5:0] y_w;
    logic [5:0] top_w;
    y_w   = {1'b0, y};
    top_w = {1'b0, top};
    return (y_w >= top_w) && (y_w <= top_w + {1'b0, PADDLE_H - 5'd1});
  endfunction

  // Score increment that sticks at the 4-bit maximum
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_referee_paddle_ctrl.sv
// One paddle: steps up/down on tick cycles, saturating at the field limits.
module paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [4:0] paddle_y_o
);

  logic [4:0] paddle_q;
  logic [4:0] paddle_d;

  // Next paddle row: move only on a tick with exactly one button, never past a limit
  always_comb begin
    paddle_d = paddle_q;
    if (tick_i) begin
      if (up_i && !down_i && (paddle_q > Y_TOP)) begin
        paddle_d = paddle_q - 5'd1;
      end else if (down_i && !up_i && (paddle_q < PADDLE_Y_MAX)) begin
        paddle_d = paddle_q + 5'd1;
      end
    end
  end

  // Paddle row register, centred on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddle_q <= PADDLE_Y_RESET;
    end else begin
      paddle_q <= paddle_d;
    end
  end

  assign paddle_y_o = paddle_q;

endmodule

// File: rtl/pong_referee.sv
// Pong referee: paddle timing, paddle-contact detection, scoring and game FSM.
module pong_referee
  import pong_pkg::*;
#(
  parameter int PADDLE_TICK = 250000,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] xPosition,
  input  logic [4:0] yPosition,
  input  logic       leftUp,
  input  logic       leftDown,
  input  logic       rightUp,
  input  logic       rightDown,
  input  logic       serve,
  output logic       isHittingLeft,
  output logic       isHittingRight,
  output logic [4:0] leftPaddleY,
  output logic [4:0] rightPaddleY,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       ballReset,
  output logic       gameOver
);

  localparam int CNT_W = (PADDLE_TICK > 1) ? $clog2(PADDLE_TICK) : 1;

  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;
  logic             tick;

  logic             serve_q;
  logic             serve_rise;

  logic             hit_left_q;
  logic             hit_left_d;
  logic             hit_right_q;
  logic             hit_right_d;

  state_e           state_q;
  state_e           state_d;
  logic [3:0]       left_score_q;
  logic [3:0]       left_score_d;
  logic [3:0]       right_score_q;
  logic [3:0]       right_score_d;
  logic             right_pt_q;
  logic             right_pt_d;
  logic [3:0]       new_score;

  // Free-running divider: tick is high for the last count of each period
  assign tick = (tick_cnt_q == CNT_W'(PADDLE_TICK - 1));

  // Divider next count wraps to zero on the tick cycle
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
  end

  // Divider register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  paddle_ctrl u_left_paddle (
    .clk        (clk),
    .rst_n      (reset),
    .tick_i     (tick),
    .up_i       (leftUp),
    .down_i     (leftDown),
    .paddle_y_o (leftPaddleY)
  );

  paddle_ctrl u_right_paddle (
    .clk        (clk),
    .rst_n      (reset),
    .tick_i     (tick),
    .up_i       (rightUp),
    .down_i     (rightDown),
    .paddle_y_o (rightPaddleY)
  );

  // Previous serve level, so only a fresh 0->1 edge starts a rally or new game
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serve_q <= 1'b0;
    end else begin
      serve_q <= serve;
    end
  end

  assign serve_rise = serve && !serve_q;

  // Contact is only judged while a rally is live
  always_comb begin
    hit_left_d  = (state_q == PLAY) && (xPosition == X_LEFT_HIT)
                  && in_paddle(yPosition, leftPaddleY);
    hit_right_d = (state_q == PLAY) && (xPosition == X_RIGHT_HIT)
                  && in_paddle(yPosition, rightPaddleY);
  end

  // Contact flags, one cycle behind the ball position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_left_q  <= 1'b0;
      hit_right_q <= 1'b0;
    end else begin
      hit_left_q  <= hit_left_d;
      hit_right_q <= hit_right_d;
    end
  end

  // Masked again so a flag from the last PLAY cycle never leaks into POINT
  assign isHittingLeft  = hit_left_q  && (state_q == PLAY);
  assign isHittingRight = hit_right_q && (state_q == PLAY);

  // Game FSM next state and score updates
  always_comb begin
    state_d       = state_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    right_pt_d    = right_pt_q;
    new_score     = right_pt_q ? sat_inc(right_score_q) : sat_inc(left_score_q);
    case (state_q)
      SERVE: begin
        if (serve_rise) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (xPosition == X_LEFT_MISS) begin
          state_d    = POINT;
          right_pt_d = 1'b1;
        end else if (xPosition == X_RIGHT_MISS) begin
          state_d    = POINT;
          right_pt_d = 1'b0;
        end
      end
      POINT: begin
        if (right_pt_q) begin
          right_score_d = new_score;
        end else begin
          left_score_d = new_score;
        end
        state_d = (new_score == 4'(WIN_SCORE)) ? GAME_OVER : SERVE;
      end
      GAME_OVER: begin
        if (serve_rise) begin
          left_score_d  = 4'd0;
          right_score_d = 4'd0;
          state_d       = SERVE;
        end
      end
      default: begin
        state_d = SERVE;
      end
    endcase
  end

  // FSM state, scores and the pending point owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SERVE;
      left_score_q  <= 4'd0;
      right_score_q <= 4'd0;
      right_pt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      right_pt_q    <= right_pt_d;
    end
  end

  assign ballReset  = (state_q == PLAY);
  assign gameOver   = (state_q == GAME_OVER);
  assign leftScore  = left_score_q;
  assign rightScore = right_score_q;

endmodule

// File: tb/tb_pong_referee.sv
module tb_pong_referee;

  localparam int PT  = 4;
  localparam int WIN = 7;

  // Model phases
  localparam int P_SERVE = 0;
  localparam int P_PLAY  = 1;
  localparam int P_POINT = 2;
  localparam int P_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] xPosition;
  logic [4:0] yPosition;
  logic       leftUp, leftDown, rightUp, rightDown, serve;
  logic       isHittingLeft, isHittingRight;
  logic [4:0] leftPaddleY, rightPaddleY;
  logic [3:0] leftScore, rightScore;
  logic       ballReset, gameOver;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pong_referee #(.PADDLE_TICK(PT), .WIN_SCORE(WIN)) dut (
    .clk            (clk),
    .reset          (reset),
    .xPosition      (xPosition),
    .yPosition      (yPosition),
    .leftUp         (leftUp),
    .leftDown       (leftDown),
    .rightUp        (rightUp),
    .rightDown      (rightDown),
    .serve          (serve),
    .isHittingLeft  (isHittingLeft),
    .isHittingRight (isHittingRight),
    .leftPaddleY    (leftPaddleY),
    .rightPaddleY   (rightPaddleY),
    .leftScore      (leftScore),
    .rightScore     (rightScore),
    .ballReset      (ballReset),
    .gameOver       (gameOver)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ly, m_ry, m_ls, m_rs, m_phase, m_cyc;
  bit m_prev_serve, m_hitl, m_hitr, m_right_pt;

  function automatic int clampi(input int v);
    if (v < 1) return 1;
    if (v > 27) return 27;
    return v;
  endfunction

  function automatic int scorei(input int s);
    return (s >= 15) ? 15 : s + 1;
  endfunction

  function automatic bit on_paddle(input int y, input int top);
    return (y >= top) && (y <= top + 3);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ly <= 14; m_ry <= 14; m_ls <= 0; m_rs <= 0;
      m_phase <= P_SERVE; m_cyc <= 0; m_prev_serve <= 1'b0;
      m_hitl <= 1'b0; m_hitr <= 1'b0; m_right_pt <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if ((m_cyc % PT) == PT - 1) begin
        m_ly <= clampi(m_ly + int'(leftDown) - int'(leftUp));
        m_ry <= clampi(m_ry + int'(rightDown) - int'(rightUp));
      end
      m_prev_serve <= serve;
      m_hitl <= (m_phase == P_PLAY) && (xPosition == 1) && on_paddle(yPosition, m_ly);
      m_hitr <= (m_phase == P_PLAY) && (xPosition == 62) && on_paddle(yPosition, m_ry);
      case (m_phase)
        P_SERVE: if (serve && !m_prev_serve) m_phase <= P_PLAY;
        P_PLAY: begin
          if (xPosition == 0) begin
            m_phase <= P_POINT; m_right_pt <= 1'b1;
          end else if (xPosition == 63) begin
            m_phase <= P_POINT; m_right_pt <= 1'b0;
          end
        end
        P_POINT: begin
          if (m_right_pt) begin
            m_rs <= scorei(m_rs);
            m_phase <= (scorei(m_rs) == WIN) ? P_OVER : P_SERVE;
          end else begin
            m_ls <= scorei(m_ls);
            m_phase <= (scorei(m_ls) == WIN) ? P_OVER : P_SERVE;
          end
        end
        default: begin
          if (serve && !m_prev_serve) begin
            m_ls <= 0; m_rs <= 0; m_phase <= P_SERVE;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_leftPaddleY",  int'(leftPaddleY),  m_ly);
      chk("cyc_rightPaddleY", int'(rightPaddleY), m_ry);
      chk("cyc_leftScore",    int'(leftScore),    m_ls);
      chk("cyc_rightScore",   int'(rightScore),   m_rs);
      chk("cyc_ballReset",    int'(ballReset),    int'(m_phase == P_PLAY));
      chk("cyc_gameOver",     int'(gameOver),     int'(m_phase == P_OVER));
      chk("cyc_hitLeft",      int'(isHittingLeft),  int'(m_hitl && m_phase == P_PLAY));
      chk("cyc_hitRight",     int'(isHittingRight), int'(m_hitr && m_phase == P_PLAY));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed stimulus with hand-computed literal expectations
  initial begin
    int prev;
    int changes;
    reset = 1'b1; serve = 1'b0; xPosition = 6'd30; yPosition = 5'd0;
    leftUp = 1'b0; leftDown = 1'b0; rightUp = 1'b0; rightDown = 1'b0;
    #2 reset = 1'b0;
    cmp_en = 1'b1;
    step(3);
    chk("rst_leftPaddleY", int'(leftPaddleY), 14);
    chk("rst_rightPaddleY", int'(rightPaddleY), 14);
    chk("rst_scores", int'({leftScore, rightScore}), 0);
    chk("rst_ballReset", int'(ballReset), 0);
    chk("rst_gameOver", int'(gameOver), 0);
    chk("rst_hits", int'({isHittingLeft, isHittingRight}), 0);
    reset = 1'b1;

    // Left paddle climbs to the top and sticks; right holds with both buttons
    leftUp = 1'b1; rightUp = 1'b1; rightDown = 1'b1;
    prev = 14; changes = 0;
    for (int i = 0; i < 20 * PT + 8; i++) begin
      step(1);
      if (int'(leftPaddleY) != prev) begin
        chk("left_step", int'(leftPaddleY), prev - 1);
        prev = int'(leftPaddleY);
        changes++;
      end
    end
    chk("left_step_count", changes, 13);
    chk("left_top_clamp", int'(leftPaddleY), 1);
    chk("right_both_hold", int'(rightPaddleY), 14);

    // Bring left paddle down to row 10
    leftUp = 1'b0; rightUp = 1'b0; rightDown = 1'b0; leftDown = 1'b1;
    for (int i = 0; i < 100 && leftPaddleY != 5'd10; i++) step(1);
    leftDown = 1'b0;
    chk("left_at_10", int'(leftPaddleY), 10);

    // Serve starts a rally
    chk("serve_ballReset_before", int'(ballReset), 0);
    serve = 1'b1; step(1); serve = 1'b0;
    chk("serve_ballReset_after", int'(ballReset), 1);

    // Contact checks (left paddle 10..13, right paddle 14..17)
    xPosition = 6'd1; yPosition = 5'd13; step(1);
    chk("hitL_y13", int'(isHittingLeft), 1);
    yPosition = 5'd14; step(1);
    chk("hitL_y14", int'(isHittingLeft), 0);
    yPosition = 5'd9; step(1);
    chk("hitL_y9", int'(isHittingLeft), 0);
    yPosition = 5'd10; step(1);
    chk("hitL_y10", int'(isHittingLeft), 1);
    xPosition = 6'd62; yPosition = 5'd17; step(1);
    chk("hitR_y17", int'(isHittingRight), 1);
    chk("hitL_off", int'(isHittingLeft), 0);
    yPosition = 5'd18; step(1);
    chk("hitR_y18", int'(isHittingRight), 0);
    xPosition = 6'd30; step(1);

    // Left miss: one POINT cycle, then right credited and back to SERVE
    xPosition = 6'd0; step(1);
    chk("point_ballReset", int'(ballReset), 0);
    chk("point_rightScore_old", int'(rightScore), 0);
    xPosition = 6'd30; step(1);
    chk("miss_rightScore", int'(rightScore), 1);
    chk("miss_gameOver", int'(gameOver), 0);
    step(1);
    chk("serve_hold_ballReset", int'(ballReset), 0);

    // Left wins six points
    for (int i = 0; i < 6; i++) begin
      serve = 1'b1; step(1); serve = 1'b0;
      xPosition = 6'd63; step(1);
      xPosition = 6'd30; step(2);
    end
    chk("left_six", int'(leftScore), 6);
    chk("right_still_one", int'(rightScore), 1);

    // Winning point with serve held high throughout
    serve = 1'b1; step(1);
    xPosition = 6'd63; step(1);
    xPosition = 6'd30; step(1);
    chk("win_leftScore", int'(leftScore), 7);
    chk("win_gameOver", int'(gameOver), 1);
    chk("win_ballReset", int'(ballReset), 0);
    step(5);
    chk("held_serve_gameOver", int'(gameOver), 1);
    chk("held_serve_leftScore", int'(leftScore), 7);
    serve = 1'b0; step(1);
    serve = 1'b1; step(1);
    chk("restart_scores", int'({leftScore, rightScore}), 0);
    chk("restart_gameOver", int'(gameOver), 0);
    chk("restart_ballReset", int'(ballReset), 0);
    serve = 1'b0; step(2);

    // Reset during PLAY with a miss pending
    serve = 1'b1; step(1); serve = 1'b0;
    chk("abort_play", int'(ballReset), 1);
    xPosition = 6'd0; reset = 1'b0;
    #1;
    chk("abort_ballReset_now", int'(ballReset), 0);
    chk("abort_leftPaddle_now", int'(leftPaddleY), 14);
    step(2);
    xPosition = 6'd30; reset = 1'b1;
    step(3);
    chk("abort_rightScore", int'(rightScore), 0);
    chk("abort_leftScore", int'(leftScore), 0);
    chk("abort_ballReset", int'(ballReset), 0);
    chk("abort_paddles", int'({leftPaddleY, rightPaddleY}), (14 << 5) | 14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
